// File: rtl/pygmy_bus_pkg.sv
// Shared encodings for the PYGMY-V32I system-bus scheduler: access sizes,
// master indices and the scheduler FSM state type.
package pygmy_bus_pkg;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    localparam int M_DBG = 0;
    localparam int M_DAT = 1;
    localparam int M_IFU = 2;
    localparam int NUM_M = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/bus_prio_arb.sv
// Combinational fixed-priority arbiter (dbg > dat > ifu) where a starved
// fetch is promoted above dat but never above dbg. Output is one-hot or zero.
module bus_prio_arb
    import pygmy_bus_pkg::*;
(
    input  logic [NUM_M-1:0] req_i,
    input  logic             starve_hit_i,
    output logic [NUM_M-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i[M_DBG]) begin
            gnt_o[M_DBG] = 1'b1;
        end else if (starve_hit_i && req_i[M_IFU]) begin
            gnt_o[M_IFU] = 1'b1;
        end else if (req_i[M_DAT]) begin
            gnt_o[M_DAT] = 1'b1;
        end else if (req_i[M_IFU]) begin
            gnt_o[M_IFU] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_sched.sv
// Single-ported bus scheduler: arbitrates dbg/dat/ifu, sequences each access
// through ACCESS and RD_LAT wait cycles, and returns done/read data to the owner.
module bus_sched
    import pygmy_bus_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dbg_req_i,
    input  logic [31:0] dbg_addr_i,
    input  logic        dbg_we_i,
    input  logic [1:0]  dbg_hb_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        dat_req_i,
    input  logic [31:0] dat_addr_i,
    input  logic        dat_we_i,
    input  logic [1:0]  dat_hb_i,
    input  logic [31:0] dat_wdata_i,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        dbg_gnt_o,
    output logic        dat_gnt_o,
    output logic        ifu_gnt_o,
    output logic        dbg_done_o,
    output logic        dat_done_o,
    output logic        ifu_done_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        bus_en_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [1:0]  bus_hb_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    output logic [1:0]  state_o
);

    localparam int unsigned      CNT_W      = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LAT - 1);
    localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);

    state_t           state_q, state_d;
    logic [NUM_M-1:0] owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [1:0]       hb_q, hb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]       starve_q, starve_d;

    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] arb_gnt;
    logic [NUM_M-1:0] gnt;
    logic             arb_en;
    logic             starve_hit;

    // Handshake: a master holds req with a stable command; gnt pulses for one
    // cycle in the cycle its command is captured. Req still high afterwards is
    // a fresh request; dropping req before gnt withdraws it.
    always_comb begin
        req        = '0;
        req[M_DBG] = dbg_req_i;
        req[M_DAT] = dat_req_i;
        req[M_IFU] = ifu_req_i;
    end

    assign starve_hit = (starve_q == STARVE_LIM) && ifu_req_i;

    bus_prio_arb u_arb (
        .req_i        (req),
        .starve_hit_i (starve_hit),
        .gnt_o        (arb_gnt)
    );

    // Gating with rst_i keeps every grant low while reset is held.
    assign arb_en = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && !rst_i;
    assign gnt    = arb_gnt & {NUM_M{arb_en}};

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        hb_d       = hb_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                owner_d = gnt;
                if (gnt[M_DBG]) begin
                    addr_d  = dbg_addr_i;
                    we_d    = dbg_we_i;
                    hb_d    = dbg_hb_i;
                    wdata_d = dbg_wdata_i;
                end else if (gnt[M_DAT]) begin
                    addr_d  = dat_addr_i;
                    we_d    = dat_we_i;
                    hb_d    = dat_hb_i;
                    wdata_d = dat_wdata_i;
                end else if (gnt[M_IFU]) begin
                    addr_d = ifu_addr_i;
                    we_d   = 1'b0;
                    hb_d   = HB_WORD;
                end
                state_d = (|gnt) ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                wait_cnt_d = '0;
                state_d    = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    rdata_d = bus_rdata_i;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only dat grants made while a fetch is waiting count toward starvation.
    always_comb begin
        starve_d = starve_q;
        if (!ifu_req_i || gnt[M_IFU]) begin
            starve_d = '0;
        end else if (gnt[M_DAT] && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            hb_q       <= HB_WORD;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            hb_q       <= hb_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= starve_d;
        end
    end

    assign dbg_gnt_o   = gnt[M_DBG];
    assign dat_gnt_o   = gnt[M_DAT];
    assign ifu_gnt_o   = gnt[M_IFU];
    assign dbg_done_o  = (state_q == ST_RESP) && owner_q[M_DBG];
    assign dat_done_o  = (state_q == ST_RESP) && owner_q[M_DAT];
    assign ifu_done_o  = (state_q == ST_RESP) && owner_q[M_IFU];
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign bus_en_o    = (state_q == ST_ACCESS);
    assign bus_we_o    = (state_q == ST_ACCESS) && we_q;
    assign bus_addr_o  = addr_q;
    assign bus_hb_o    = hb_q;
    assign bus_wdata_o = wdata_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_bus_sched.sv
// Directed bench for bus_sched (RD_LAT=2, STARVE_MAX=4): per-cycle expected
// control vectors plus address/data checks for each scenario.
module tb_bus_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dbg_req_i = 1'b0;
    logic [31:0] dbg_addr_i = '0;
    logic        dbg_we_i = 1'b0;
    logic [1:0]  dbg_hb_i = 2'b00;
    logic [31:0] dbg_wdata_i = '0;
    logic        dat_req_i = 1'b0;
    logic [31:0] dat_addr_i = '0;
    logic        dat_we_i = 1'b0;
    logic [1:0]  dat_hb_i = 2'b00;
    logic [31:0] dat_wdata_i = '0;
    logic        ifu_req_i = 1'b0;
    logic [31:0] ifu_addr_i = '0;
    logic [31:0] bus_rdata_i = '0;
    logic        dbg_gnt_o, dat_gnt_o, ifu_gnt_o;
    logic        dbg_done_o, dat_done_o, ifu_done_o;
    logic [31:0] rdata_o;
    logic        busy_o, bus_en_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [1:0]  bus_hb_o, state_o;

    // {dbg_gnt, dat_gnt, ifu_gnt, dbg_done, dat_done, ifu_done, bus_en, bus_we}
    logic [7:0]  ctl;
    assign ctl = {dbg_gnt_o, dat_gnt_o, ifu_gnt_o, dbg_done_o, dat_done_o,
                  ifu_done_o, bus_en_o, bus_we_o};

    int checks = 0;
    int failures = 0;

    bus_sched #(.RD_LAT(2), .STARVE_MAX(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dbg_req_i   (dbg_req_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_hb_i    (dbg_hb_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dat_req_i   (dat_req_i),
        .dat_addr_i  (dat_addr_i),
        .dat_we_i    (dat_we_i),
        .dat_hb_i    (dat_hb_i),
        .dat_wdata_i (dat_wdata_i),
        .ifu_req_i   (ifu_req_i),
        .ifu_addr_i  (ifu_addr_i),
        .dbg_gnt_o   (dbg_gnt_o),
        .dat_gnt_o   (dat_gnt_o),
        .ifu_gnt_o   (ifu_gnt_o),
        .dbg_done_o  (dbg_done_o),
        .dat_done_o  (dat_done_o),
        .ifu_done_o  (ifu_done_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .bus_en_o    (bus_en_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_hb_o    (bus_hb_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .state_o     (state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if (ctl !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b want %b", ctl, 8'b0);
        end
        checks++;
        if ({busy_o, state_o, bus_hb_o} !== {1'b0, 2'd0, 2'b10}) begin
            failures++;
            $display("FAIL reset_state: got busy=%b st=%0d hb=%b want busy=0 st=0 hb=10",
                     busy_o, state_o, bus_hb_o);
        end
        checks++;
        if ({bus_addr_o, bus_wdata_o, rdata_o} !== 96'b0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want zeros",
                     bus_addr_o, bus_wdata_o, rdata_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_ifu_read();
        logic [7:0] exp_ctl [6];
        exp_ctl = '{8'b00100000, 8'b00000010, 8'b0, 8'b0, 8'b00000100, 8'b0};
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            case (c)
                0: begin ifu_req_i = 1'b1; ifu_addr_i = 32'h100; end
                1: ifu_req_i = 1'b0;
                3: bus_rdata_i = 32'hDEADBEEF;
                4: bus_rdata_i = 32'h0;
                default: ;
            endcase
            #1;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL ifu_read_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]);
            end
            if (c == 1) begin
                checks++;
                if ({bus_addr_o, bus_hb_o} !== {32'h100, 2'b10}) begin
                    failures++;
                    $display("FAIL ifu_read_addr: got %h/%b want 00000100/10", bus_addr_o, bus_hb_o);
                end
            end
            if (c == 3 || c >= 4) begin
                checks++;
                if (rdata_o !== ((c == 3) ? 32'h0 : 32'hDEADBEEF)) begin
                    failures++;
                    $display("FAIL ifu_read_rdata c%0d: got %h want %h", c, rdata_o,
                             (c == 3) ? 32'h0 : 32'hDEADBEEF);
                end
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ifu_read_idle: got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_dat_write();
        logic [7:0] exp_ctl [4];
        exp_ctl = '{8'b01000000, 8'b00000011, 8'b00001000, 8'b0};
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            case (c)
                0: begin
                    dat_req_i = 1'b1; dat_we_i = 1'b1; dat_addr_i = 32'h2000;
                    dat_hb_i = 2'b01; dat_wdata_i = 32'h12345678;
                end
                1: begin dat_req_i = 1'b0; dat_we_i = 1'b0; end
                default: ;
            endcase
            #1;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL dat_write_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]);
            end
        end
        checks++;
        if ({bus_addr_o, bus_hb_o, bus_wdata_o} !== {32'h2000, 2'b01, 32'h12345678}) begin
            failures++;
            $display("FAIL dat_write_latch: got %h/%b/%h want 00002000/01/12345678",
                     bus_addr_o, bus_hb_o, bus_wdata_o);
        end
        checks++;
        if (rdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL dat_write_rdata: got %h want deadbeef", rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ctl [12];
        exp_ctl = '{8'b10000000, 8'b00000010, 8'b0, 8'b0, 8'b01010000, 8'b00000011,
                    8'b00101000, 8'b00000010, 8'b0, 8'b0, 8'b00000100, 8'b0};
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            case (c)
                0: begin
                    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h10; dbg_hb_i = 2'b10;
                    dat_req_i = 1'b1; dat_we_i = 1'b1; dat_addr_i = 32'h20; dat_hb_i = 2'b10;
                    dat_wdata_i = 32'hCAFE;
                    ifu_req_i = 1'b1; ifu_addr_i = 32'h30;
                end
                1: dbg_req_i = 1'b0;
                3: bus_rdata_i = 32'h11112222;
                5: begin dat_req_i = 1'b0; dat_we_i = 1'b0; end
                7: ifu_req_i = 1'b0;
                9: bus_rdata_i = 32'h33334444;
                default: ;
            endcase
            #1;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL b2b_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]);
            end
            if (c == 1 || c == 5 || c == 7) begin
                checks++;
                if (bus_addr_o !== ((c == 1) ? 32'h10 : (c == 5) ? 32'h20 : 32'h30)) begin
                    failures++;
                    $display("FAIL b2b_addr c%0d: got %h", c, bus_addr_o);
                end
            end
            if (c == 4 || c == 10) begin
                checks++;
                if (rdata_o !== ((c == 4) ? 32'h11112222 : 32'h33334444)) begin
                    failures++;
                    $display("FAIL b2b_rdata c%0d: got %h", c, rdata_o);
                end
            end
        end
    endtask

    task automatic test_starve();
        logic [7:0] exp_ctl [16];
        exp_ctl = '{8'b01000000, 8'b00000011, 8'b01001000, 8'b00000011,
                    8'b01001000, 8'b00000011, 8'b01001000, 8'b00000011,
                    8'b00101000, 8'b00000010, 8'b0, 8'b0,
                    8'b01000100, 8'b00000011, 8'b00001000, 8'b0};
        for (int c = 0; c < 16; c++) begin
            if (c > 0) tick();
            case (c)
                0: begin
                    dat_req_i = 1'b1; dat_we_i = 1'b1; dat_addr_i = 32'h40;
                    dat_hb_i = 2'b10; dat_wdata_i = 32'h55;
                    ifu_req_i = 1'b1; ifu_addr_i = 32'h200;
                end
                11: bus_rdata_i = 32'h0BADF00D;
                13: begin dat_req_i = 1'b0; dat_we_i = 1'b0; ifu_req_i = 1'b0; end
                default: ;
            endcase
            #1;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL starve_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]);
            end
            if (c == 9) begin
                checks++;
                if (bus_addr_o !== 32'h200) begin
                    failures++;
                    $display("FAIL starve_ifu_addr: got %h want 00000200", bus_addr_o);
                end
            end
            if (c == 12) begin
                checks++;
                if (rdata_o !== 32'h0BADF00D) begin
                    failures++;
                    $display("FAIL starve_rdata: got %h want 0badf00d", rdata_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] exp_ctl [6];
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h80; dbg_hb_i = 2'b10;
        tick();
        dbg_req_i = 1'b0;
        tick();
        #1;
        checks++;
        if ({busy_o, state_o} !== {1'b1, 2'd2}) begin
            failures++;
            $display("FAIL rst_mid_pre: got busy=%b st=%0d want busy=1 st=2", busy_o, state_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({ctl, busy_o, state_o, bus_hb_o} !== {8'b0, 1'b0, 2'd0, 2'b10}) begin
            failures++;
            $display("FAIL rst_mid_ctl: got ctl=%b busy=%b st=%0d hb=%b want 0/0/0/10",
                     ctl, busy_o, state_o, bus_hb_o);
        end
        checks++;
        if ({bus_addr_o, bus_wdata_o, rdata_o} !== 96'b0) begin
            failures++;
            $display("FAIL rst_mid_data: got addr=%h wdata=%h rdata=%h want zeros",
                     bus_addr_o, bus_wdata_o, rdata_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (ctl !== 8'b0) begin
                failures++;
                $display("FAIL rst_mid_nodone c%0d: got %b want 0", c, ctl);
            end
        end
        exp_ctl = '{8'b01000000, 8'b00000010, 8'b0, 8'b0, 8'b00001000, 8'b0};
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            case (c)
                0: begin
                    dat_req_i = 1'b1; dat_we_i = 1'b0; dat_addr_i = 32'h300; dat_hb_i = 2'b00;
                end
                1: dat_req_i = 1'b0;
                3: bus_rdata_i = 32'h77;
                default: ;
            endcase
            #1;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL rst_mid_new_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]);
            end
            if (c == 0) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_mid_from_idle: got busy=%b want 0", busy_o);
                end
            end
        end
        checks++;
        if ({bus_addr_o, bus_hb_o, rdata_o} !== {32'h300, 2'b00, 32'h77}) begin
            failures++;
            $display("FAIL rst_mid_new_data: got %h/%b/%h want 00000300/00/00000077",
                     bus_addr_o, bus_hb_o, rdata_o);
        end
    endtask

    task automatic test_withdraw();
        logic [7:0] exp_ctl [7];
        exp_ctl = '{8'b10000000, 8'b00000010, 8'b0, 8'b0, 8'b00010000, 8'b0, 8'b0};
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            case (c)
                0: begin
                    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h90; dbg_hb_i = 2'b10;
                    dat_req_i = 1'b1; dat_we_i = 1'b1; dat_addr_i = 32'hA0; dat_hb_i = 2'b10;
                    dat_wdata_i = 32'h99;
                end
                1: dbg_req_i = 1'b0;
                2: dat_req_i = 1'b0;
                3: bus_rdata_i = 32'h1234;
                default: ;
            endcase
            #1;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL withdraw_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]);
            end
        end
        checks++;
        if ({busy_o, bus_addr_o, rdata_o} !== {1'b0, 32'h90, 32'h1234}) begin
            failures++;
            $display("FAIL withdraw_final: got busy=%b addr=%h rdata=%h want 0/00000090/00001234",
                     busy_o, bus_addr_o, rdata_o);
        end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        tick();
        test_dat_write();
        tick();
        test_back_to_back();
        tick();
        test_starve();
        tick();
        test_reset_mid_access();
        tick();
        test_withdraw();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
